multiport_fifo: RTL and testbench
=================================

# multiport_fifo

Synchronous multi-port FIFO that accepts up to N_WR entries and retires up to N_RD entries per clock. It uses first-word-fall-through read presentation and adds a flush input. It is the successor to the single-port registered-read FIFO and is intended for the superscalar fetch/decode and dispatch queues, where several instructions move per cycle and a branch mispredict must empty the queue in one cycle.

## Interface
- WIDTH, 32: bits per entry
- DEPTH, 16: entries; power of two, DEPTH >= max(N_WR, N_RD)
- N_WR, 2: max writes per cycle
- N_RD, 2: max reads per cycle
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears pointers and count
- flush  in  1  synchronous, active-high; empties queue, same effect as reset on state
- wr_num  in  clog2(N_WR+1)  number of entries offered this cycle (0..N_WR)
- wr_data  in  N_WR*WIDTH  packed; slot k at bits [k*WIDTH +: WIDTH]; slot 0 oldest
- wr_accepted  out  1  combinational; offered entries taken this cycle
- rd_num  in  clog2(N_RD+1)  number of entries to pop this cycle (0..N_RD)
- rd_data  out  N_RD*WIDTH  packed; slot k = k-th oldest entry (combinational from storage)
- rd_valid  out  N_RD  bit k = 1 iff count > k
- count  out  clog2(DEPTH+1)  registered occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- wr_ready  out  1  DEPTH - count >= N_WR (a full-width write fits without a read)

## Operation
- State: storage DEPTH x WIDTH (not reset), rptr/wptr of clog2(DEPTH) bits wrapping modulo DEPTH, count register.
- rd_acc = min(rd_num, count). An over-request pops only the valid entries; it is not an error.
- wr_acc = wr_num if wr_num <= DEPTH - count + rd_acc, else 0. Writes are all-or-nothing, with no partial acceptance.
- wr_accepted = (wr_num != 0) && (wr_acc == wr_num). It is 0 when wr_num == 0.
- On an accepted write, slot k goes to mem[(wptr+k) mod DEPTH] for k < wr_num. Then wptr += wr_acc and rptr += rd_acc.
- count_next = count + wr_acc - rd_acc. Compute at clog2(DEPTH+1)+1 bits; the result never exceeds DEPTH and never underflows.
- rd_data slot k = mem[(rptr+k) mod DEPTH] when rd_valid[k], else don't-care.
- full, empty, wr_ready and rd_valid are decoded from the count register only. They do not depend on same-cycle inputs.
- Priority is reset > flush > normal operation.
  - On reset or flush: rptr = wptr = count = 0 next cycle.
  - Same-cycle writes and reads are discarded.
  - wr_accepted is forced to 0 during reset/flush cycles.

## Timing
- Reset values (cycle after reset high): count = 0, empty = 1, full = 0, wr_ready = 1, rd_valid = 0.
- rd_data is don't-care after reset. No output is X-gated.
- Write-to-read latency is 1 cycle. An entry written at edge t appears on rd_data/rd_valid after edge t. There is no same-cycle write-to-read bypass, even when empty.
- Pop is 0-cycle presentation: the consumer samples rd_data/rd_valid and asserts rd_num in the same cycle, and the entries retire at the edge.
- Simultaneous read+write while full: accepted if wr_num <= rd_acc; count changes by wr_acc - rd_acc.
- Simultaneous read+write while empty: rd_acc = 0, and the write is accepted if wr_num <= DEPTH.
- Pointer wrap is seamless. Multi-slot reads and writes may straddle index DEPTH-1 -> 0 with order preserved.
- Reset or flush asserted mid-stream takes effect at that edge. Queued data is lost and the storage contents are stale but unreachable.

## Test plan
Bench parameters: DEPTH=8, N_WR=2, N_RD=2.
- Reset, idle 3 cycles -> count=0, empty=1, full=0, wr_ready=1, rd_valid=00, wr_accepted=0.
- wr_num=2 for 4 cycles with data 0x1..0x8, then wr_num=1 with 0x9 -> after cycle 4: count=8, full=1, wr_ready=0; 0x9 gives wr_accepted=0, count stays 8.
- Full with 0x1..0x8, rd_num=2 + wr_num=2 (0xA,0xB) same cycle -> wr_accepted=1, count=8. Subsequent pops return 0x3..0x8,0xA,0xB in order.
- Wrap: repeat wr_num=2 / rd_num=2 for 20 cycles with incrementing data -> every popped slot-0/slot-1 pair equals the expected sequence, and count is constant at 2 after fill.
- count=1 (entry 0x5), rd_num=2 + wr_num=2 (0x6,0x7) -> only 0x5 popped. Next cycle count=2, rd_data = {0x7,0x6}, rd_valid=11.
- count=6, flush=1 with wr_num=2 -> wr_accepted=0. Next cycle count=0, empty=1, rd_valid=00. Then a write of 0xC is visible one cycle later in slot 0.

Source files
------------

// File: rtl/multiport_fifo.sv
// Multi-port FIFO with first-word-fall-through read slots and a one-cycle flush.
// Up to N_WR entries are written and up to N_RD entries are retired per clock.
module multiport_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int N_WR  = 2,
  parameter int N_RD  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [$clog2(N_WR+1)-1:0]  wr_num,
  input  logic [N_WR*WIDTH-1:0]      wr_data,
  output logic                       wr_accepted,
  input  logic [$clog2(N_RD+1)-1:0]  rd_num,
  output logic [N_RD*WIDTH-1:0]      rd_data,
  output logic [N_RD-1:0]            rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = CW + 1;
  localparam int WNW = $clog2(N_WR + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;

  logic [XW-1:0] w_count_x;
  logic [XW-1:0] w_rd_req;
  logic [XW-1:0] w_wr_req;
  logic [XW-1:0] w_rd_acc;
  logic [XW-1:0] w_wr_acc;
  logic [XW-1:0] w_space;
  logic [XW-1:0] w_count_next;
  logic          w_wr_fits;
  logic          w_clear;
  logic          w_do_write;
  logic          w_unused_msb;
  logic [PW-1:0] w_wr_idx [N_WR];
  logic [N_WR-1:0] w_wr_en;

  assign w_count_x = XW'(r_count);
  assign w_rd_req  = XW'(rd_num);
  assign w_wr_req  = XW'(wr_num);
  assign w_clear   = reset || flush;

  // An over-request retires only what is present; the freed slots count as space
  // for a same-cycle write, which is all-or-nothing.
  assign w_rd_acc     = (w_rd_req < w_count_x) ? w_rd_req : w_count_x;
  assign w_space      = XW'(DEPTH) - w_count_x + w_rd_acc;
  assign w_wr_fits    = (w_wr_req <= w_space);
  assign w_wr_acc     = w_wr_fits ? w_wr_req : '0;
  assign w_count_next = w_count_x + w_wr_acc - w_rd_acc;
  assign w_unused_msb = w_count_next[XW-1];
  assign w_do_write   = w_wr_fits && !w_clear;

  assign wr_accepted = (wr_num != '0) && w_do_write;

  generate
    for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr_slot
      assign w_wr_idx[gi] = r_wptr + PW'(gi);
      assign w_wr_en[gi]  = w_do_write && (WNW'(gi) < wr_num);
    end
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd_slot
      assign rd_data[gi*WIDTH +: WIDTH] = r_mem[r_rptr + PW'(gi)];
      assign rd_valid[gi]               = (r_count > CW'(gi));
    end
  endgenerate

  // Storage is intentionally not reset; stale entries become unreachable once
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_WR; k++) begin
      if (w_wr_en[k]) begin
        r_mem[w_wr_idx[k]] <= wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + PW'(w_rd_acc);
      r_wptr  <= r_wptr + PW'(w_wr_acc);
      r_count <= w_count_next[CW-1:0];
    end
  end

  assign count    = r_count;
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign wr_ready = ((XW'(DEPTH) - w_count_x) >= XW'(N_WR));

endmodule

// File: tb/tb_multiport_fifo.sv
// Directed bench for multiport_fifo with a queue scoreboard: entries are pushed
// when a write is expected to be accepted and compared as they reach the read slots.
module tb_multiport_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int N_WR  = 2;
  localparam int N_RD  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [1:0]          wr_num;
  logic [N_WR*WIDTH-1:0] wr_data;
  logic                wr_accepted;
  logic [1:0]          rd_num;
  logic [N_RD*WIDTH-1:0] rd_data;
  logic [N_RD-1:0]     rd_valid;
  logic [3:0]          count;
  logic                full;
  logic                empty;
  logic                wr_ready;

  int tests = 0;
  int fails = 0;
  logic [31:0] q[$];
  logic [31:0] next_val;

  multiport_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_WR(N_WR), .N_RD(N_RD)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_num(wr_num), .wr_data(wr_data), .wr_accepted(wr_accepted),
    .rd_num(rd_num), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock of stimulus. Outputs are checked at the falling edge against the
  // scoreboard, then the scoreboard is advanced after the rising edge.
  task automatic cycle(input int wn, input logic [31:0] d0, input logic [31:0] d1,
                       input int rn, input bit fl = 1'b0, input bit rs = 1'b0);
    int  sz;
    int  racc;
    bit  exp_acc;
    reset   = rs;
    flush   = fl;
    wr_num  = wn[1:0];
    rd_num  = rn[1:0];
    wr_data = {d1, d0};
    @(negedge clk);
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("wr_ready", 64'(wr_ready), 64'((DEPTH - sz) >= N_WR));
    chk("rd_valid", 64'(rd_valid), 64'({sz > 1, sz > 0}));
    for (int k = 0; k < N_RD; k++) begin
      if (k < sz) chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*WIDTH +: WIDTH]), 64'(q[k]));
    end
    racc    = (rn < sz) ? rn : sz;
    exp_acc = (wn != 0) && (wn <= DEPTH - sz + racc) && !rs && !fl;
    chk("wr_accepted", 64'(wr_accepted), 64'(exp_acc));
    $display("[TB] t=%0t rs=%0b fl=%0b wn=%0d d0=%0h d1=%0h rn=%0d count=%0d acc=%0b rd_valid=%b",
             $time, rs, fl, wn, d0, d1, rn, count, wr_accepted, rd_valid);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete();
    end else begin
      repeat (racc) void'(q.pop_front());
      if (exp_acc) begin
        q.push_back(d0);
        if (wn == 2) q.push_back(d1);
      end
    end
    reset  = 1'b0;
    flush  = 1'b0;
    wr_num = '0;
    rd_num = '0;
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    wr_num  = '0;
    rd_num  = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state held across idle cycles
    repeat (3) cycle(0, 0, 0, 0);

    // Fill to full, then an extra write is refused
    for (int i = 0; i < 4; i++) cycle(2, 32'(2*i + 1), 32'(2*i + 2), 0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_wr_ready", 64'(wr_ready), 64'd0);
    cycle(1, 32'h9, 32'h0, 0);
    chk("overflow_count", 64'(count), 64'd8);

    // Read and write together while full
    cycle(2, 32'hA, 32'hB, 2);
    chk("full_rw_count", 64'(count), 64'd8);
    chk("full_rw_head", 64'(rd_data[31:0]), 64'h3);
    repeat (4) cycle(0, 0, 0, 2);
    chk("drained_empty", 64'(empty), 64'd1);

    // Sustained two-in/two-out traffic wraps the pointers several times
    next_val = 32'h100;
    for (int i = 0; i < 20; i++) begin
      cycle(2, next_val, next_val + 32'h1, 2);
      next_val = next_val + 32'h2;
      chk("wrap_count", 64'(count), 64'd2);
    end

    // Over-request pops only the single valid entry
    cycle(0, 0, 0, 2);
    cycle(1, 32'h5, 32'h0, 0);
    cycle(2, 32'h6, 32'h7, 2);
    chk("overreq_count", 64'(count), 64'd2);
    chk("overreq_rd_data", 64'(rd_data), 64'h00000007_00000006);
    chk("overreq_rd_valid", 64'(rd_valid), 64'b11);

    // Flush with a competing write discards everything
    cycle(2, 32'h20, 32'h21, 0);
    cycle(2, 32'h22, 32'h23, 0);
    chk("preflush_count", 64'(count), 64'd6);
    cycle(2, 32'h24, 32'h25, 1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_rd_valid", 64'(rd_valid), 64'b00);
    cycle(1, 32'hC, 32'h0, 0);
    chk("postflush_head", 64'(rd_data[31:0]), 64'hC);
    chk("postflush_rd_valid", 64'(rd_valid), 64'b01);

    // Reset mid-stream beats a same-cycle write
    cycle(2, 32'h30, 32'h31, 0);
    cycle(2, 32'h32, 32'h33, 0, 1'b1, 1'b1);
    chk("reset_count", 64'(count), 64'd0);
    cycle(2, 32'h40, 32'h41, 0);
    cycle(0, 0, 0, 2);
    cycle(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
